// File: rtl/noc_tg_pkg.sv
// Definitions shared by the NoC traffic generator and the receive-side checker.
package noc_tg_pkg;

    localparam int unsigned SEQ_LSB   = 0;
    localparam int unsigned ERR_SEQ   = 0;
    localparam int unsigned ERR_DEST  = 1;
    localparam int unsigned ERR_FRAME = 2;
    localparam int unsigned ERR_W     = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        RUNNING = 1'b1
    } tg_state_e;

    // Injection timestamp occupies the upper half of tdata.
    function automatic int unsigned ts_lsb(input int unsigned tdata_w);
        return tdata_w / 2;
    endfunction

endpackage

// File: rtl/axis_tr_lat_stats.sv
// Latency accumulator: running sum, minimum and maximum of valid samples.
module axis_tr_lat_stats #(
    parameter int unsigned LAT_WIDTH = 32,
    parameter int unsigned SUM_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 i_clr,
    input  logic                 i_vld,
    input  logic [LAT_WIDTH-1:0] i_lat,
    output logic [SUM_WIDTH-1:0] o_sum,
    output logic [LAT_WIDTH-1:0] o_min,
    output logic [LAT_WIDTH-1:0] o_max
);

    logic [SUM_WIDTH-1:0] r_sum;
    logic [LAT_WIDTH-1:0] r_min;
    logic [LAT_WIDTH-1:0] r_max;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_sum <= '0;
            r_min <= '1;
            r_max <= '0;
        end else if (i_vld) begin
            r_sum <= r_sum + SUM_WIDTH'(i_lat);
            if (i_lat < r_min) r_min <= i_lat;
            if (i_lat > r_max) r_max <= i_lat;
        end
    end

    assign o_sum = r_sum;
    assign o_min = r_min;
    assign o_max = r_max;

endmodule

// File: rtl/axis_tr_checker.sv
// AXI-Stream receive checker: counts, validates and timestamps single-beat NoC packets.
// Define AXIS_TR_SEQ_CHECK_EN to enable per-source sequence checking (error_flags[0]).
module axis_tr_checker
    import noc_tg_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned TDATA_WIDTH = 512,
    parameter int unsigned TDEST_WIDTH = 2,
    parameter int unsigned TID_WIDTH   = 2,
    parameter int unsigned NUM_ROUTERS = 4,
    parameter int unsigned DEST_ID     = 0,
    parameter int unsigned LAT_WIDTH   = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_start,
    input  logic [COUNT_WIDTH-1:0]             i_num_packets,
    input  logic [TDATA_WIDTH/2-1:0]           i_ticks,
    input  logic                               i_axis_in_tvalid,
    output logic                               o_axis_in_tready,
    input  logic [TDATA_WIDTH-1:0]             i_axis_in_tdata,
    input  logic                               i_axis_in_tlast,
    input  logic [TID_WIDTH-1:0]               i_axis_in_tid,
    input  logic [TDEST_WIDTH-1:0]             i_axis_in_tdest,
    output logic                               o_done,
    output logic [NUM_ROUTERS*COUNT_WIDTH-1:0] o_recv_packets,
    output logic [COUNT_WIDTH-1:0]             o_total_recv_packets,
    output logic [LAT_WIDTH+COUNT_WIDTH-1:0]   o_latency_sum,
    output logic [LAT_WIDTH-1:0]               o_latency_min,
    output logic [LAT_WIDTH-1:0]               o_latency_max,
    output logic [ERR_W-1:0]                   o_error_flags,
    output logic [COUNT_WIDTH-1:0]             o_error_count
);

    localparam int unsigned TS_W   = TDATA_WIDTH / 2;
    localparam int unsigned TS_LSB = ts_lsb(TDATA_WIDTH);
    localparam int unsigned SUM_W  = LAT_WIDTH + COUNT_WIDTH;
    localparam logic [TID_WIDTH:0]     NR_LIM = (TID_WIDTH+1)'(NUM_ROUTERS);
    localparam logic [TDEST_WIDTH-1:0] MY_ID  = TDEST_WIDTH'(DEST_ID);

    tg_state_e              r_state;
    logic                   r_done;
    logic                   r_tready;
    logic                   r_s1_vld;
    logic [TID_WIDTH-1:0]   r_s1_tid;
    logic [TDEST_WIDTH-1:0] r_s1_tdest;
    logic                   r_s1_tlast;
    logic [LAT_WIDTH-1:0]   r_s1_lat;
    logic [COUNT_WIDTH-1:0] r_recv [NUM_ROUTERS];
    logic [COUNT_WIDTH-1:0] r_total;
    logic [ERR_W-1:0]       r_flags;
    logic [COUNT_WIDTH-1:0] r_err_cnt;

    logic                   w_hs;
    logic [TS_W-1:0]        w_ts;
    logic [TS_W-1:0]        w_lat_full;
    logic                   w_tid_ok;
    logic [ERR_W-1:0]       w_err;
    logic                   w_clr;
    logic                   w_unused_pad;

    assign w_hs       = i_axis_in_tvalid & r_tready;
    assign w_ts       = i_axis_in_tdata[TS_LSB +: TS_W];
    assign w_lat_full = i_ticks - w_ts;
    assign w_tid_ok   = {1'b0, r_s1_tid} < NR_LIM;
    assign w_clr      = ~rst_n;
    assign w_unused_pad = &{1'b0, i_axis_in_tdata[TS_LSB-1:COUNT_WIDTH]};

    // Run control; beats flow regardless of state, only done follows it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_done   <= 1'b1;
            r_tready <= 1'b0;
        end else begin
            r_tready <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= RUNNING;
                        r_done  <= 1'b0;
                    end
                end
                RUNNING: begin
                    if (r_total >= i_num_packets) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

    // Stage 1: capture beat fields and the modulo-wrapped latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_tid   <= '0;
            r_s1_tdest <= '0;
            r_s1_tlast <= 1'b0;
            r_s1_lat   <= '0;
        end else begin
            r_s1_vld <= w_hs;
            if (w_hs) begin
                r_s1_tid   <= i_axis_in_tid;
                r_s1_tdest <= i_axis_in_tdest;
                r_s1_tlast <= i_axis_in_tlast;
                r_s1_lat   <= LAT_WIDTH'(w_lat_full);
            end
        end
    end

`ifdef AXIS_TR_SEQ_CHECK_EN
    logic [COUNT_WIDTH-1:0] r_s1_seq;

    always_ff @(posedge clk) begin
        if (!rst_n)    r_s1_seq <= '0;
        else if (w_hs) r_s1_seq <= i_axis_in_tdata[SEQ_LSB +: COUNT_WIDTH];
    end

    // Compared against the live count, which already holds the previous beat's
    // increment, so back-to-back beats from one source see an up-to-date value.
    assign w_err[ERR_SEQ] = w_tid_ok && (r_s1_seq != r_recv[r_s1_tid]);
`else
    logic w_unused_seq;
    assign w_unused_seq   = &{1'b0, i_axis_in_tdata[SEQ_LSB +: COUNT_WIDTH]};
    assign w_err[ERR_SEQ] = 1'b0;
`endif

    assign w_err[ERR_DEST]  = (r_s1_tdest != MY_ID) || !w_tid_ok;
    assign w_err[ERR_FRAME] = ~r_s1_tlast;

    // Stage 2: counters and sticky error state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_ROUTERS; i++) r_recv[i] <= '0;
            r_total   <= '0;
            r_flags   <= '0;
            r_err_cnt <= '0;
        end else if (r_s1_vld) begin
            r_total <= r_total + COUNT_WIDTH'(1);
            if (w_tid_ok) r_recv[r_s1_tid] <= r_recv[r_s1_tid] + COUNT_WIDTH'(1);
            r_flags <= r_flags | w_err;
            if (|w_err) r_err_cnt <= r_err_cnt + COUNT_WIDTH'(1);
        end
    end

    axis_tr_lat_stats #(
        .LAT_WIDTH (LAT_WIDTH),
        .SUM_WIDTH (SUM_W)
    ) u_lat_stats (
        .clk   (clk),
        .i_clr (w_clr),
        .i_vld (r_s1_vld),
        .i_lat (r_s1_lat),
        .o_sum (o_latency_sum),
        .o_min (o_latency_min),
        .o_max (o_latency_max)
    );

    for (genvar g = 0; g < NUM_ROUTERS; g++) begin : g_recv
        assign o_recv_packets[g*COUNT_WIDTH +: COUNT_WIDTH] = r_recv[g];
    end

    assign o_done               = r_done;
    assign o_axis_in_tready     = r_tready;
    assign o_total_recv_packets = r_total;
    assign o_error_flags        = r_flags;
    assign o_error_count        = r_err_cnt;

endmodule

// File: tb/tb_axis_tr_checker.sv
// Randomized bench for axis_tr_checker against a beat-level reference model.
module tb_axis_tr_checker;

    localparam int unsigned CW = 32;
    localparam int unsigned DW = 512;
    localparam int unsigned TW = 256;
    localparam int unsigned NR = 4;
    localparam int unsigned LW = 32;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [CW-1:0]   num_packets;
    logic [TW-1:0]   ticks;
    logic            tvalid;
    logic            tready;
    logic [DW-1:0]   tdata;
    logic            tlast;
    logic [1:0]      tid;
    logic [1:0]      tdest;
    logic            done;
    logic [NR*CW-1:0] recv_flat;
    logic [CW-1:0]   total;
    logic [LW+CW-1:0] lat_sum;
    logic [LW-1:0]   lat_min;
    logic [LW-1:0]   lat_max;
    logic [2:0]      err_flags;
    logic [CW-1:0]   err_count;

    axis_tr_checker dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_start              (start),
        .i_num_packets        (num_packets),
        .i_ticks              (ticks),
        .i_axis_in_tvalid     (tvalid),
        .o_axis_in_tready     (tready),
        .i_axis_in_tdata      (tdata),
        .i_axis_in_tlast      (tlast),
        .i_axis_in_tid        (tid),
        .i_axis_in_tdest      (tdest),
        .o_done               (done),
        .o_recv_packets       (recv_flat),
        .o_total_recv_packets (total),
        .o_latency_sum        (lat_sum),
        .o_latency_min        (lat_min),
        .o_latency_max        (lat_max),
        .o_error_flags        (err_flags),
        .o_error_count        (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted beat becomes visible two edges after acceptance.
    typedef struct {
        bit          vld;
        logic [1:0]  tid;
        logic [1:0]  tdest;
        bit          tlast;
        logic [31:0] seq;
        logic [31:0] lat;
    } beat_t;

    beat_t       pend;
    logic [31:0] m_recv [NR];
    logic [31:0] m_total, m_err_cnt, m_min, m_max;
    logic [63:0] m_sum;
    logic [2:0]  m_flags;
    bit          m_run, m_tready;

    function automatic void m_reset();
        for (int i = 0; i < NR; i++) m_recv[i] = 0;
        m_total = 0; m_err_cnt = 0; m_sum = 0;
        m_min = 32'hffff_ffff; m_max = 0; m_flags = 0;
        m_run = 0; m_tready = 0; pend.vld = 0;
    endfunction

    function automatic void m_apply(input beat_t b);
        bit e_seq, e_dest, e_frame;
        e_dest  = (b.tdest != 2'd0) || (int'(b.tid) >= NR);
        e_frame = !b.tlast;
        e_seq   = 0;
`ifdef AXIS_TR_SEQ_CHECK_EN
        if (int'(b.tid) < NR) e_seq = (b.seq != m_recv[b.tid]);
`endif
        if (e_seq)   m_flags[0] = 1'b1;
        if (e_dest)  m_flags[1] = 1'b1;
        if (e_frame) m_flags[2] = 1'b1;
        if (e_seq || e_dest || e_frame) m_err_cnt++;
        if (int'(b.tid) < NR) m_recv[b.tid]++;
        m_total++;
        m_sum += 64'(b.lat);
        if (b.lat < m_min) m_min = b.lat;
        if (b.lat > m_max) m_max = b.lat;
    endfunction

    always @(posedge clk) begin
        logic [TW-1:0] diff;
        beat_t         nb;
        if (!rst_n) begin
            m_reset();
        end else begin
            if (!m_run) begin
                if (start) m_run = 1;
            end else if (m_total >= num_packets) begin
                m_run = 0;
            end
            if (pend.vld) m_apply(pend);
            nb.vld   = tvalid && m_tready;
            diff     = ticks - tdata[DW-1:TW];
            nb.tid   = tid;
            nb.tdest = tdest;
            nb.tlast = tlast;
            nb.seq   = tdata[31:0];
            nb.lat   = diff[31:0];
            pend     = nb;
            m_tready = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("done", 64'(done), 64'(!m_run));
            check("tready", 64'(tready), 64'(m_tready));
            for (int i = 0; i < NR; i++)
                check($sformatf("recv[%0d]", i), 64'(recv_flat[i*CW +: CW]), 64'(m_recv[i]));
            check("total", 64'(total), 64'(m_total));
            check("lat_sum", lat_sum, m_sum);
            check("lat_min", 64'(lat_min), 64'(m_min));
            check("lat_max", 64'(lat_max), 64'(m_max));
            check("err_flags", 64'(err_flags), 64'(m_flags));
            check("err_count", 64'(err_count), 64'(m_err_cnt));
        end
    end

    // Stimulus helpers; inputs change 1 time unit after a rising edge.
    int unsigned sent [NR];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        tvalid = 0;
        repeat (n) step();
    endtask

    task automatic beat(input logic [1:0] t, input logic [31:0] sq, input logic [1:0] d,
                        input bit l, input logic [TW-1:0] ts, input logic [TW-1:0] tk);
        tvalid = 1; tid = t; tdest = d; tlast = l; ticks = tk;
        tdata = '0;
        tdata[DW-1:TW] = ts;
        tdata[31:0]    = sq;
        sent[t]++;
        step();
    endtask

    task automatic do_reset();
        rst_n = 0; tvalid = 0; start = 0;
        step(); step();
        rst_n = 1;
        for (int i = 0; i < NR; i++) sent[i] = 0;
        step();
    endtask

    function automatic logic [TW-1:0] rand_wide();
        logic [TW-1:0] v;
        for (int i = 0; i < TW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [TW-1:0] ts, tk;
        rst_n = 0; start = 0; num_packets = 0; ticks = 0;
        tvalid = 0; tdata = '0; tlast = 1; tid = 0; tdest = 0;
        for (int i = 0; i < NR; i++) sent[i] = 0;
        @(posedge clk);
        #1 chk_en = 1;
        do_reset();

        check("rst_done", 64'(done), 64'd1);
        check("rst_tready", 64'(tready), 64'd1);
        check("rst_total", 64'(total), 64'd0);
        check("rst_min", 64'(lat_min), 64'hffff_ffff);

        // Four beats, latency 10 each, alternating sources 0/1.
        num_packets = 4;
        start = 1; step(); start = 0;
        check("run_done_low", 64'(done), 64'd0);
        beat(0, 0, 0, 1, 990, 1000);
        beat(1, 0, 0, 1, 990, 1000);
        beat(0, 1, 0, 1, 990, 1000);
        beat(1, 1, 0, 1, 990, 1000);
        idle(4);
        check("b_recv0", 64'(recv_flat[0 +: CW]), 64'd2);
        check("b_recv1", 64'(recv_flat[CW +: CW]), 64'd2);
        check("b_recv2", 64'(recv_flat[2*CW +: CW]), 64'd0);
        check("b_sum", lat_sum, 64'd40);
        check("b_min", 64'(lat_min), 64'd10);
        check("b_max", 64'(lat_max), 64'd10);
        check("b_flags", 64'(err_flags), 64'd0);
        check("b_done", 64'(done), 64'd1);

        // Back-to-back beats from one source.
        beat(2, 0, 0, 1, 5, 7);
        beat(2, 1, 0, 1, 5, 7);
        beat(2, 2, 0, 1, 5, 7);
        idle(3);
        check("c_recv2", 64'(recv_flat[2*CW +: CW]), 64'd3);
        check("c_flags", 64'(err_flags), 64'd0);
        check("c_errcnt", 64'(err_count), 64'd0);

        // Wrong sequence number from source 3.
        do_reset();
        beat(3, 5, 0, 1, 0, 1);
        idle(3);
`ifdef AXIS_TR_SEQ_CHECK_EN
        check("d_flags", 64'(err_flags), 64'b001);
        check("d_errcnt", 64'(err_count), 64'd1);
`else
        check("d_flags", 64'(err_flags), 64'b000);
        check("d_errcnt", 64'(err_count), 64'd0);
`endif
        check("d_recv3", 64'(recv_flat[3*CW +: CW]), 64'd1);

        // Wrong destination and missing tlast on one beat.
        do_reset();
        beat(0, 0, 1, 0, 0, 3);
        idle(3);
        check("e_flags", 64'(err_flags), 64'b110);
        check("e_errcnt", 64'(err_count), 64'd1);

        // Timestamp counter wrap.
        do_reset();
        ts = '1; ts = ts - 2;
        beat(0, 0, 0, 1, ts, 2);
        idle(3);
        check("f_min", 64'(lat_min), 64'd5);
        check("f_max", 64'(lat_max), 64'd5);
        check("f_sum", lat_sum, 64'd5);

        // Random traffic with a reset in the middle of a run.
        do_reset();
        num_packets = CW'($urandom_range(20, 60));
        start = 1; step(); start = 0;
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                rst_n = 0; tvalid = 1;
                step();
                do_reset();
                num_packets = CW'($urandom_range(20, 60));
                start = 1; step(); start = 0;
            end
            start = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) < 7) begin
                logic [1:0]  t;
                logic [31:0] sq;
                t  = 2'($urandom_range(0, 3));
                sq = ($urandom_range(0, 9) == 0) ? $urandom : sent[t];
                ts = rand_wide();
                tk = ($urandom_range(0, 7) == 0) ? rand_wide() : ts + TW'($urandom_range(0, 1000));
                beat(t, sq, ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                     $urandom_range(0, 9) != 0, ts, tk);
            end else begin
                idle(1);
            end
        end
        start = 0;
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
